// File: rtl/vx_stream_rr_arbiter_if.sv
// vx_stream_rr_arbiter_if: valid/ready bundle for the N:1 round-robin
// stream arbiter (request side in, merged stream out).
interface vx_stream_rr_arbiter_if #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 1
);
  localparam int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [NUM_REQS-1:0]       valid_in;
  logic [NUM_REQS*DATAW-1:0] data_in;
  logic [NUM_REQS-1:0]       ready_in;

  logic                      valid_out;
  logic [DATAW-1:0]          data_out;
  logic [LOG_NUM_REQS-1:0]   sel_out;
  logic                      ready_out;

  modport master (
    output valid_in,
    output data_in,
    input  ready_in,
    input  valid_out,
    input  data_out,
    input  sel_out,
    output ready_out
  );

  modport slave (
    input  valid_in,
    input  data_in,
    output ready_in,
    output valid_out,
    output data_out,
    output sel_out,
    input  ready_out
  );
endinterface

// File: rtl/vx_stream_rr_arbiter.sv
// vx_stream_rr_arbiter: round-robin N:1 stream merge, with either a
// one-entry registered output or a combinational output with grant lock.
module vx_stream_rr_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 1,
  parameter bit OUT_REG  = 1'b1
) (
  input logic                   clk,
  input logic                   reset,
  vx_stream_rr_arbiter_if.slave bus
);
  localparam int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam logic [LOG_NUM_REQS-1:0] LAST_RST =
    LOG_NUM_REQS'(NUM_REQS - 1);

  logic [LOG_NUM_REQS-1:0] last;
  logic [LOG_NUM_REQS-1:0] arb_idx;
  logic [LOG_NUM_REQS-1:0] gnt_idx;
  logic                    gnt_valid;
  logic [DATAW-1:0]        gnt_data;
  logic                    xfer_in;

  // first valid stream searching upward from last+1, wrapping
  always_comb begin
    logic found;
    int   j;
    found   = 1'b0;
    j       = 0;
    arb_idx = last;
    for (int i = 1; i <= NUM_REQS; i++) begin
      j = (int'(last) + i) % NUM_REQS;
      if (!found && bus.valid_in[j]) begin
        found   = 1'b1;
        arb_idx = LOG_NUM_REQS'(j);
      end
    end
  end

  assign gnt_valid = bus.valid_in[gnt_idx];
  assign gnt_data  = bus.data_in[int'(gnt_idx)*DATAW +: DATAW];

  // at most the granted stream sees ready, and only when it transfers
  always_comb begin
    bus.ready_in = '0;
    if (xfer_in) begin
      bus.ready_in[gnt_idx] = 1'b1;
    end
  end

  // priority pointer moves only on an accepted input beat
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= LAST_RST;
    end else if (xfer_in) begin
      last <= gnt_idx;
    end
  end

  if (OUT_REG) begin : g_reg
    logic                    out_valid;
    logic [DATAW-1:0]        out_data;
    logic [LOG_NUM_REQS-1:0] out_sel;
    logic                    stage_ready;

    assign stage_ready = bus.ready_out || !out_valid;
    assign gnt_idx     = arb_idx;
    assign xfer_in     = !reset && gnt_valid && stage_ready;

    // output slot occupancy: fill on accept, drain on downstream ready
    always_ff @(posedge clk) begin
      if (reset) begin
        out_valid <= 1'b0;
      end else if (xfer_in) begin
        out_valid <= 1'b1;
      end else if (bus.ready_out) begin
        out_valid <= 1'b0;
      end
    end

    // payload and winner index; only loaded when a beat is accepted
    always_ff @(posedge clk) begin
      if (xfer_in) begin
        out_data <= gnt_data;
        out_sel  <= gnt_idx;
      end
    end

    assign bus.valid_out = out_valid;
    assign bus.data_out  = out_data;
    assign bus.sel_out   = out_sel;

`ifndef SYNTHESIS
    a_hold_out: assert property (@(posedge clk) disable iff (reset)
      bus.valid_out && !bus.ready_out |=>
        bus.valid_out && $stable(bus.data_out) && $stable(bus.sel_out));
`endif
  end else begin : g_comb
    logic                    lock_valid;
    logic [LOG_NUM_REQS-1:0] lock_idx;

    assign gnt_idx       = lock_valid ? lock_idx : arb_idx;
    assign xfer_in       = !reset && gnt_valid && bus.ready_out;
    assign bus.valid_out = !reset && (|bus.valid_in);
    assign bus.data_out  = gnt_data;
    assign bus.sel_out   = gnt_idx;

    // pin the grant while the output is stalled so data stays stable
    always_ff @(posedge clk) begin
      if (reset) begin
        lock_valid <= 1'b0;
        lock_idx   <= '0;
      end else if (bus.valid_out && bus.ready_out) begin
        lock_valid <= 1'b0;
      end else if (bus.valid_out) begin
        lock_valid <= 1'b1;
        lock_idx   <= gnt_idx;
      end
    end
  end

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) $onehot0(bus.ready_in));

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_chk
    a_no_retract: assert property (@(posedge clk) disable iff (reset)
      bus.valid_in[i] && !bus.ready_in[i] |=>
        bus.valid_in[i] &&
        $stable(bus.data_in[i*DATAW +: DATAW]));
  end
`endif
endmodule

// File: tb/tb_vx_stream_rr_arbiter.sv
// tb_vx_stream_rr_arbiter: directed checks of both output modes
// (registered and combinational-with-lock) with 4 streams of 8 bits.
module tb_vx_stream_rr_arbiter;
  localparam logic [31:0] DATA = 32'hA3A2A1A0;

  logic clk;
  logic rst_r;
  logic rst_c;
  int   checks;
  int   errors;

  vx_stream_rr_arbiter_if #(.NUM_REQS(4), .DATAW(8)) r_bus ();
  vx_stream_rr_arbiter_if #(.NUM_REQS(4), .DATAW(8)) c_bus ();

  vx_stream_rr_arbiter #(
    .NUM_REQS(4), .DATAW(8), .OUT_REG(1'b1)
  ) u_reg (
    .clk  (clk),
    .reset(rst_r),
    .bus  (r_bus)
  );

  vx_stream_rr_arbiter #(
    .NUM_REQS(4), .DATAW(8), .OUT_REG(1'b0)
  ) u_comb (
    .clk  (clk),
    .reset(rst_c),
    .bus  (c_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_r = 1'b1;
    rst_c = 1'b1;
    r_bus.valid_in  = 4'b1111;
    r_bus.data_in   = DATA;
    r_bus.ready_out = 1'b1;
    c_bus.valid_in  = 4'b0000;
    c_bus.data_in   = DATA;
    c_bus.ready_out = 1'b0;

    // reset held two cycles
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_vout", r_bus.valid_out, 0);
    check("rst_rdy", r_bus.ready_in, 0);
    rst_r = 1'b0;
    #1;
    check("first_gnt", r_bus.ready_in, 4'b0001);

    // fair rotation, one beat per cycle
    @(negedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      check("rot_vout", r_bus.valid_out, 1);
      check("rot_sel", r_bus.sel_out, k % 4);
      check("rot_data", r_bus.data_out, 8'hA0 + k % 4);
      @(negedge clk);
      #1;
    end

    // backpressure on beat sel 0
    r_bus.ready_out = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_vout", r_bus.valid_out, 1);
      check("bp_sel", r_bus.sel_out, 0);
      check("bp_data", r_bus.data_out, 8'hA0);
      check("bp_rdy", r_bus.ready_in, 0);
      @(negedge clk);
    end
    r_bus.ready_out = 1'b1;
    #1;
    check("bp_rel_rdy", r_bus.ready_in, 4'b0010);
    check("bp_rel_data", r_bus.data_out, 8'hA0);
    @(negedge clk);
    #1;
    check("bp_next_sel", r_bus.sel_out, 1);
    check("bp_next_data", r_bus.data_out, 8'hA1);

    // sparse wrap-around, streams 1 and 3
    rst_r = 1'b1;
    @(negedge clk);
    r_bus.valid_in = 4'b1010;
    @(negedge clk);
    rst_r = 1'b0;
    #1;
    check("sp_first", r_bus.ready_in, 4'b0010);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("sp_sel", r_bus.sel_out, (k % 2 == 1) ? 3 : 1);
      check("sp_data", r_bus.data_out, (k % 2 == 1) ? 8'hA3 : 8'hA1);
    end

    // reset during a stall at sel 2
    rst_r = 1'b1;
    r_bus.ready_out = 1'b0;
    @(negedge clk);
    r_bus.valid_in = 4'b0100;
    @(negedge clk);
    rst_r = 1'b0;
    #1;
    check("ms_rdy", r_bus.ready_in, 4'b0100);
    @(negedge clk);
    #1;
    check("ms_vout", r_bus.valid_out, 1);
    check("ms_sel", r_bus.sel_out, 2);
    check("ms_data", r_bus.data_out, 8'hA2);
    r_bus.valid_in = 4'b0101;
    #1;
    check("ms_stall_rdy", r_bus.ready_in, 0);
    rst_r = 1'b1;
    @(negedge clk);
    #1;
    check("ms_rst_vout", r_bus.valid_out, 0);
    rst_r = 1'b0;
    r_bus.ready_out = 1'b1;
    #1;
    check("ms_gnt", r_bus.ready_in, 4'b0001);
    @(negedge clk);
    #1;
    check("ms_sel0", r_bus.sel_out, 0);
    check("ms_data0", r_bus.data_out, 8'hA0);
    @(negedge clk);
    #1;
    check("ms_sel2", r_bus.sel_out, 2);
    check("ms_data2", r_bus.data_out, 8'hA2);
    rst_r = 1'b1;

    // combinational mode: reset and first grants
    c_bus.valid_in  = 4'b1111;
    c_bus.ready_out = 1'b1;
    @(negedge clk);
    #1;
    check("c_rst_vout", c_bus.valid_out, 0);
    check("c_rst_rdy", c_bus.ready_in, 0);
    rst_c = 1'b0;
    #1;
    check("c_vout", c_bus.valid_out, 1);
    check("c_sel", c_bus.sel_out, 0);
    check("c_data", c_bus.data_out, 8'hA0);
    check("c_rdy", c_bus.ready_in, 4'b0001);
    @(negedge clk);
    #1;
    check("c_sel_next", c_bus.sel_out, 1);
    check("c_data_next", c_bus.data_out, 8'hA1);

    // grant lock against a later higher-priority request
    rst_c = 1'b1;
    @(negedge clk);
    c_bus.valid_in  = 4'b0100;
    c_bus.ready_out = 1'b0;
    @(negedge clk);
    rst_c = 1'b0;
    #1;
    check("lk_vout", c_bus.valid_out, 1);
    check("lk_sel", c_bus.sel_out, 2);
    check("lk_data", c_bus.data_out, 8'hA2);
    check("lk_rdy", c_bus.ready_in, 0);
    @(negedge clk);
    c_bus.valid_in = 4'b0101;
    #1;
    check("lk_hold_sel", c_bus.sel_out, 2);
    check("lk_hold_data", c_bus.data_out, 8'hA2);
    @(negedge clk);
    #1;
    check("lk_hold_sel2", c_bus.sel_out, 2);
    c_bus.ready_out = 1'b1;
    #1;
    check("lk_rel_rdy", c_bus.ready_in, 4'b0100);
    @(negedge clk);
    c_bus.valid_in = 4'b0001;
    #1;
    check("lk_next_sel", c_bus.sel_out, 0);
    check("lk_next_data", c_bus.data_out, 8'hA0);
    check("lk_next_rdy", c_bus.ready_in, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vx_stream_rr_arbiter.md
# vx_stream_rr_arbiter

Round-robin N:1 stream arbiter that merges NUM_REQS valid/ready request streams into one output stream. It sits directly upstream of a bypass buffer (e.g. memory-request or writeback merge points) and feeds that buffer's valid_in/data_in/ready_in handshake. It reports the winning index with each beat. It guarantees fairness and a stable output while the output is stalled.

## Interface
- NUM_REQS, default 4: number of input streams, ≥1.
- DATAW, default 1: payload width per stream.
- OUT_REG, default 1: 1 = registered one-entry output stage (latency 1); 0 = combinational output with grant lock.
- LOG_NUM_REQS (localparam): max(1, $clog2(NUM_REQS)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  NUM_REQS  per-stream valid.
- data_in  in  NUM_REQS*DATAW  stream i occupies bits [i*DATAW +: DATAW].
- ready_in  out  NUM_REQS  per-stream ready; at most one bit is set (one-hot or zero).
- valid_out  out  1  output valid.
- data_out  out  DATAW  granted payload.
- sel_out  out  LOG_NUM_REQS  index of the stream that produced data_out.
- ready_out  in  1  downstream ready.

## Operation
- Transfer on stream i: valid_in[i] && ready_in[i]. Output transfer: valid_out && ready_out.
- Priority pointer `last` (LOG_NUM_REQS bits). Search order: (last+1) mod NUM_REQS upward, wrapping. The grant is the first valid stream in that order.
- `last` is updated to the granted index only on an input transfer. It never changes on cycles without an accepted input.
- Reset: `last` = NUM_REQS-1, so stream 0 has top priority. Output register valid = 0. Lock = 0. Data register is not reset.
- OUT_REG=1:
  - stage_ready = ready_out || !out_valid.
  - ready_in[g] = stage_ready && valid_in[g] for grant g; all other bits are 0.
  - On an input transfer, the register loads data_in[g] and g, and out_valid is set to 1.
  - Otherwise, if ready_out, out_valid is cleared.
  - data_out/sel_out are held stable while valid_out && !ready_out.
- OUT_REG=0:
  - valid_out = |valid_in. data_out = data_in[g]. sel_out = g. ready_in[g] = ready_out.
  - Lock register: set when valid_out && !ready_out, storing g. Cleared on output transfer.
  - While locked, g = stored index regardless of new higher-priority requests.
- Upstream protocol: valid_in[i], once raised, is held with stable data until its transfer. The block does not tolerate retraction (covered by an assertion).
- NUM_REQS=1: degenerates to a pass-through (OUT_REG=0) or a pipeline register (OUT_REG=1). sel_out is constant 0.
- All idle: ready_in = 0 and no state change, except out_valid clearing per the OUT_REG=1 rule.

## Timing
- After reset: valid_out=0 and ready_in=0. sel_out/data_out are don't-care while valid_out=0.
- OUT_REG=1:
  - Latency 1: an input accepted at edge k gives valid_out=1 from edge k to the next handshake.
  - Throughput 1 beat/cycle under continuous ready_out.
  - ready_in depends combinationally on ready_out and valid_in. valid_out/data_out/sel_out are register outputs.
- OUT_REG=0:
  - Latency 0. Combinational paths: valid_in→valid_out/data_out/sel_out and ready_out→ready_in.
  - Lock takes effect from the edge after the first stalled cycle.
- Simultaneous output drain and new input (OUT_REG=1): the register is reloaded in the same edge with no bubble.
- Reset mid-operation: a stalled beat is dropped, and `last`/lock return to reset values on the next edge.

## Test plan
- Reset:
  - Stimulus: hold reset 2 cycles with valid_in=4'b1111, then release.
  - Response: valid_out=0 and ready_in=0 during reset. The first grant after release is sel 0.
- Fair rotation:
  - Stimulus: OUT_REG=1, valid_in=4'b1111 constant, ready_out=1, data i = 8'hA0+i.
  - Response: data_out sequence A0,A1,A2,A3,A0,… starting 1 cycle after the first accept, one beat per cycle.
- Backpressure:
  - Stimulus: OUT_REG=1, ready_out=0 for 3 cycles after the first beat (sel 0).
  - Response: valid_out held, data_out=A0 stable, ready_in=0. After ready_out=1, next sel=1 with no beat lost or duplicated.
- Grant lock:
  - Stimulus: OUT_REG=0, only valid_in[2], ready_out=0; stream 0 raises valid the next cycle.
  - Response: sel_out stays 2 until handshake. The next grant is sel 0, since 3 is idle and the search wraps.
- Sparse wrap-around:
  - Stimulus: only streams 1 and 3 valid continuously.
  - Response: sel alternates 1,3,1,3. `last` wraps 3→search from 0 and finds 1.
- Reset mid-stall:
  - Stimulus: OUT_REG=1, valid_out=1 with ready_out=0 at sel 2; assert reset 1 cycle.
  - Response: valid_out=0 next cycle. The next grant follows reset priority (stream 0 first).
